// File: rtl/fetch_bpred.sv
// Fetch-stage PC generator with a direct-mapped BTB and 2-bit saturating
// direction counters. Predicts taken transfers at fetch, trains and redirects
// from resolved outcomes in execute.
module fetch_bpred #(
    parameter int unsigned       XLEN        = 32,
    parameter int unsigned       BTB_ENTRIES = 16,
    parameter logic [XLEN-1:0]   RESET_PC    = '0,
    parameter logic [1:0]        CNT_INIT    = 2'b10
) (
    input  logic            clk_fetch,
    input  logic            i_reset,
    input  logic            i_stall,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc,
    input  logic            i_upd_en,
    input  logic [XLEN-1:0] i_upd_pc,
    input  logic            i_upd_taken,
    input  logic [XLEN-1:0] i_upd_target,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_pc_next,
    output logic            o_pred_taken,
    output logic [XLEN-1:0] o_pred_target,
    output logic            o_btb_hit,
    output logic [31:0]     o_redirect_cnt
);

    localparam int unsigned IDX  = $clog2(BTB_ENTRIES);
    localparam int unsigned TAGW = XLEN - IDX - 2;

    logic            r_valid  [BTB_ENTRIES];
    logic [TAGW-1:0] r_tag    [BTB_ENTRIES];
    logic [XLEN-1:0] r_target [BTB_ENTRIES];
    logic [1:0]      r_ctr    [BTB_ENTRIES];

    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_redirect_cnt;

    logic [IDX-1:0]  w_lk_idx;
    logic [TAGW-1:0] w_lk_tag;
    logic            w_lk_hit;
    logic [IDX-1:0]  w_up_idx;
    logic [TAGW-1:0] w_up_tag;
    logic            w_up_hit;
    logic [XLEN-1:0] w_pc_next;
    logic [1:0]      w_unused_lsbs;

    // Byte offset of the resolved PC carries no indexing information.
    assign w_unused_lsbs = i_upd_pc[1:0];

    // Index/tag split for fetch lookup and execute update.
    assign w_lk_idx = r_pc[IDX+1:2];
    assign w_lk_tag = r_pc[XLEN-1:IDX+2];
    assign w_up_idx = i_upd_pc[IDX+1:2];
    assign w_up_tag = i_upd_pc[XLEN-1:IDX+2];

    assign w_lk_hit = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);

    // Next-PC select: execute redirect, then prediction, then sequential.
    always_comb begin
        w_pc_next = r_pc + XLEN'(4);
        if (i_redirect) begin
            w_pc_next = i_redirect_pc;
        end else if (w_lk_hit && r_ctr[w_lk_idx][1]) begin
            w_pc_next = r_target[w_lk_idx];
        end
    end

    // Fetch PC register; a redirect overrides a hazard stall.
    always_ff @(posedge clk_fetch or negedge i_reset) begin
        if (!i_reset) begin
            r_pc <= RESET_PC;
        end else if (!i_stall || i_redirect) begin
            r_pc <= w_pc_next;
        end
    end

    // Saturating count of accepted redirects.
    always_ff @(posedge clk_fetch or negedge i_reset) begin
        if (!i_reset) begin
            r_redirect_cnt <= '0;
        end else if (i_redirect && (r_redirect_cnt != '1)) begin
            r_redirect_cnt <= r_redirect_cnt + 32'd1;
        end
    end

    // BTB training: counter walk on hit, allocate on taken miss.
    always_ff @(posedge clk_fetch or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= 2'b01;
            end
        end else if (i_upd_en) begin
            if (w_up_hit) begin
                if (i_upd_taken) begin
                    r_target[w_up_idx] <= i_upd_target;
                    if (r_ctr[w_up_idx] != 2'b11) begin
                        r_ctr[w_up_idx] <= r_ctr[w_up_idx] + 2'd1;
                    end
                end else if (r_ctr[w_up_idx] != 2'b00) begin
                    r_ctr[w_up_idx] <= r_ctr[w_up_idx] - 2'd1;
                end
            end else if (i_upd_taken) begin
                r_valid[w_up_idx]  <= 1'b1;
                r_tag[w_up_idx]    <= w_up_tag;
                r_target[w_up_idx] <= i_upd_target;
                r_ctr[w_up_idx]    <= CNT_INIT;
            end
        end
    end

    assign o_pc           = r_pc;
    assign o_pc_next      = w_pc_next;
    assign o_btb_hit      = w_lk_hit;
    assign o_pred_taken   = w_lk_hit && r_ctr[w_lk_idx][1];
    assign o_pred_target  = w_lk_hit ? r_target[w_lk_idx] : '0;
    assign o_redirect_cnt = r_redirect_cnt;

endmodule

// File: tb/tb_fetch_bpred.sv
// Bench for fetch_bpred: directed scenarios then randomized traffic, checked
// every cycle against an abstract BTB/PC model.
module tb_fetch_bpred;

    localparam int unsigned N = 16;

    logic        clk_fetch = 1'b0;
    logic        i_reset;
    logic        i_stall;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        i_upd_en;
    logic [31:0] i_upd_pc;
    logic        i_upd_taken;
    logic [31:0] i_upd_target;
    logic [31:0] o_pc;
    logic [31:0] o_pc_next;
    logic        o_pred_taken;
    logic [31:0] o_pred_target;
    logic        o_btb_hit;
    logic [31:0] o_redirect_cnt;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    // Reference state: one record per BTB slot, plus PC and redirect count.
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    bit          m_valid [N];
    logic [31:0] m_tag   [N];
    logic [31:0] m_tgt   [N];
    int          m_ctr   [N];

    fetch_bpred #(
        .XLEN(32), .BTB_ENTRIES(16), .RESET_PC(32'h0), .CNT_INIT(2'b10)
    ) dut (
        .clk_fetch(clk_fetch), .i_reset(i_reset), .i_stall(i_stall),
        .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
        .i_upd_en(i_upd_en), .i_upd_pc(i_upd_pc), .i_upd_taken(i_upd_taken),
        .i_upd_target(i_upd_target), .o_pc(o_pc), .o_pc_next(o_pc_next),
        .o_pred_taken(o_pred_taken), .o_pred_target(o_pred_target),
        .o_btb_hit(o_btb_hit), .o_redirect_cnt(o_redirect_cnt)
    );

    always #5 clk_fetch = ~clk_fetch;

    function automatic int slot(input logic [31:0] pc);
        return int'((pc / 4) % N);
    endfunction

    function automatic logic [31:0] tagof(input logic [31:0] pc);
        return pc / (4 * N);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc  = 32'h0;
        m_cnt = 32'h0;
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
            m_tgt[i]   = '0;
            m_ctr[i]   = 1;
        end
    endtask

    task automatic model_lookup(output bit hit, output bit pred,
                                output logic [31:0] tgt, output logic [31:0] nxt);
        int k;
        k    = slot(m_pc);
        hit  = m_valid[k] && (m_tag[k] == tagof(m_pc));
        pred = hit && (m_ctr[k] >= 2);
        tgt  = hit ? m_tgt[k] : 32'h0;
        if (i_redirect)  nxt = i_redirect_pc;
        else if (pred)   nxt = tgt;
        else             nxt = m_pc + 32'd4;
    endtask

    task automatic compare();
        bit hit, pred;
        logic [31:0] tgt, nxt;
        model_lookup(hit, pred, tgt, nxt);
        chk("pc",          o_pc,              m_pc);
        chk("btb_hit",     32'(o_btb_hit),    32'(hit));
        chk("pred_taken",  32'(o_pred_taken), 32'(pred));
        chk("pred_target", o_pred_target,     tgt);
        chk("pc_next",     o_pc_next,         nxt);
        chk("redirect_cnt", o_redirect_cnt,   m_cnt);
    endtask

    // Apply one clock edge to the model using the inputs held across it.
    task automatic model_edge();
        bit hit, pred;
        logic [31:0] tgt, nxt;
        int k;
        model_lookup(hit, pred, tgt, nxt);
        if (i_upd_en) begin
            k = slot(i_upd_pc);
            if (m_valid[k] && m_tag[k] == tagof(i_upd_pc)) begin
                if (i_upd_taken) begin
                    m_ctr[k] = (m_ctr[k] + 1 > 3) ? 3 : m_ctr[k] + 1;
                    m_tgt[k] = i_upd_target;
                end else begin
                    m_ctr[k] = (m_ctr[k] - 1 < 0) ? 0 : m_ctr[k] - 1;
                end
            end else if (i_upd_taken) begin
                m_valid[k] = 1'b1;
                m_tag[k]   = tagof(i_upd_pc);
                m_tgt[k]   = i_upd_target;
                m_ctr[k]   = 2;
            end
        end
        if (!i_stall || i_redirect) m_pc = nxt;
        if (i_redirect && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
    endtask

    task automatic cycle();
        @(negedge clk_fetch);
        compare();
        @(posedge clk_fetch);
        model_edge();
        #1;
    endtask

    task automatic idle();
        i_stall = 0; i_redirect = 0; i_redirect_pc = '0;
        i_upd_en = 0; i_upd_pc = '0; i_upd_taken = 0; i_upd_target = '0;
    endtask

    task automatic upd(input logic [31:0] pc, input bit taken, input logic [31:0] tgt);
        i_upd_en = 1; i_upd_pc = pc; i_upd_taken = taken; i_upd_target = tgt;
    endtask

    task automatic redir(input logic [31:0] pc);
        i_redirect = 1; i_redirect_pc = pc;
    endtask

    // Asynchronous reset pulse issued between clock edges.
    task automatic do_reset();
        idle();
        i_reset = 0;
        #1;
        model_reset();
        compare();
        @(posedge clk_fetch);
        #1;
        compare();
        i_reset = 1;
    endtask

    function automatic logic [31:0] rand_pc();
        return 32'($urandom_range(0, 63)) * 32'd4;
    endfunction

    initial begin
        i_reset = 1;
        idle();
        #2;

        // Reset and free-running sequential fetch.
        do_reset();
        chk("reset_pc", o_pc, 32'h0);
        chk("reset_next", o_pc_next, 32'h4);
        repeat (3) cycle();

        // Allocate 0x10 -> 0x40 then fetch through it.
        upd(32'h10, 1, 32'h40);
        cycle();
        idle();
        #1;
        chk("alloc_hit_pc", o_pc, 32'h10);
        chk("alloc_hit", 32'(o_btb_hit), 32'h1);
        chk("alloc_next", o_pc_next, 32'h40);
        cycle();
        chk("alloc_jump", o_pc, 32'h40);
        cycle();

        // Counter walk: allocate, two not-taken, then taken to saturation.
        do_reset();
        i_stall = 1;
        upd(32'h10, 1, 32'h40); cycle();
        upd(32'h10, 0, 32'h0);  cycle();
        upd(32'h10, 0, 32'h0);  cycle();
        idle(); redir(32'h10); cycle();
        idle();
        #1;
        chk("weak_nt_pred", 32'(o_pred_taken), 32'h0);
        chk("weak_nt_next", o_pc_next, 32'h14);
        i_stall = 1;
        repeat (4) begin upd(32'h10, 1, 32'h44); cycle(); end
        upd(32'h10, 0, 32'h0); cycle();
        idle(); redir(32'h10); cycle();
        idle();
        #1;
        chk("sat_pred", 32'(o_pred_taken), 32'h1);
        chk("sat_target", o_pred_target, 32'h44);
        cycle();

        // Alias: 0x50 replaces 0x10 in the same slot.
        upd(32'h50, 1, 32'h80); cycle();
        idle(); redir(32'h10); cycle();
        idle(); redir(32'h50); cycle();
        idle();
        #1;
        chk("alias_next", o_pc_next, 32'h80);
        cycle();

        // Stall holds; redirect overrides stall.
        redir(32'h20); cycle();
        idle(); i_stall = 1; cycle(); cycle();
        chk("stall_hold", o_pc, 32'h20);
        redir(32'h100); cycle();
        idle();
        #1;
        chk("stall_redirect", o_pc, 32'h100);
        cycle();

        // Same-cycle lookup/update sees the old contents.
        do_reset();
        redir(32'hC); cycle();
        idle(); cycle();
        upd(32'h10, 1, 32'h40);
        #1;
        chk("rbw_pred", 32'(o_pred_taken), 32'h0);
        cycle();
        idle(); redir(32'h10); cycle();
        idle(); cycle();

        // Sequential wrap at the top of the address space.
        redir(32'hFFFF_FFFC); cycle();
        idle();
        #1;
        chk("wrap_next", o_pc_next, 32'h0);
        cycle();

        // Mid-run reset must empty every slot.
        upd(32'h30, 1, 32'h90); cycle();
        do_reset();
        for (int i = 0; i < int'(N); i++) begin
            idle(); redir(32'(i) * 32'd4); cycle();
        end
        idle(); cycle();

        // Randomized traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            idle();
            i_stall = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) == 0) redir(rand_pc());
            if ($urandom_range(0, 1) == 0)
                upd($urandom_range(0, 1) ? m_pc : rand_pc(),
                    1'($urandom_range(0, 1)), rand_pc());
            cycle();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
